// File: rtl/ekf_result_hub_pkg.sv
// Shared types and helpers for the EKF result hub: sequencer states,
// display constants and the SOC-to-integer-percent saturation.
package ekf_hub_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STOP,
        S_DRAIN
    } hub_state_e;

    localparam logic [6:0] BLANK   = 7'd127;
    localparam logic [6:0] SOC_MAX = 7'd100;

    // Word is passed zero-extended to 64 bits so one function serves any DATA_W.
    function automatic logic [6:0] soc_to_int(input logic [63:0] word,
                                              input int          data_w,
                                              input int          frac_w);
        logic [6:0] field;
        field = word[frac_w +: 7];
        if (word[data_w-1])
            return 7'd0;
        if (field > SOC_MAX)
            return SOC_MAX;
        return field;
    endfunction

endpackage

// File: rtl/ekf_result_hub_alarm.sv
// Per-channel low/high SOC alarm pair with hysteresis, updated only when a
// new result is captured for the channel.
module ekf_alarm_hyst #(
    parameter int LOW_TH  = 20,
    parameter int HIGH_TH = 95,
    parameter int HYST    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap,
    input  logic [6:0] soc_int,
    output logic       low_alarm,
    output logic       high_alarm
);

    localparam logic [7:0] LOW_SET  = 8'(LOW_TH);
    localparam logic [7:0] LOW_CLR  = 8'(LOW_TH + HYST);
    localparam logic [7:0] HIGH_SET = 8'(HIGH_TH);
    localparam logic [7:0] HIGH_CLR = 8'(HIGH_TH - HYST);

    logic [7:0] v;
    assign v = {1'b0, soc_int};

    always_ff @(posedge clk) begin
        if (rst) begin
            low_alarm  <= 1'b0;
            high_alarm <= 1'b0;
        end else if (cap) begin
            // Inside the hysteresis band neither branch fires, so state holds.
            if (v < LOW_SET)
                low_alarm <= 1'b1;
            else if (v >= LOW_CLR)
                low_alarm <= 1'b0;
            if (v > HIGH_SET)
                high_alarm <= 1'b1;
            else if (v <= HIGH_CLR)
                high_alarm <= 1'b0;
        end
    end

endmodule

// File: rtl/ekf_result_hub.sv
// Result hub between the charge/discharge EKF engines and the display path:
// stop/drain/restart mode sequencing, per-channel capture and alarms, display scan.
module ekf_result_hub
    import ekf_hub_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 24,
    parameter int FRAC_W      = 16,
    parameter int LOW_TH      = 20,
    parameter int HIGH_TH     = 95,
    parameter int HYST        = 2,
    parameter int DRAIN_TO    = 1024,
    parameter int SCAN_CYCLES = 50000,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode_req,
    input  logic                     start_req,
    input  logic                     stop_req,
    input  logic                     eng_busy,
    input  logic [N_CH-1:0]          ch_done,
    input  logic [N_CH*DATA_W-1:0]   ch_soc,
    input  logic [N_CH*DATA_W-1:0]   ch_vrc,
    output logic                     mode_o,
    output logic                     start_o,
    output logic                     stop_o,
    output logic                     running,
    output logic [N_CH*DATA_W-1:0]   soc_q,
    output logic [N_CH*DATA_W-1:0]   vrc_q,
    output logic [N_CH-1:0]          valid_q,
    output logic [N_CH-1:0]          low_alarm,
    output logic [N_CH-1:0]          high_alarm,
    output logic [CH_W-1:0]          disp_ch,
    output logic [6:0]               disp_soc
);

    localparam int DR_W = $clog2(DRAIN_TO);
    localparam int DW_W = $clog2(SCAN_CYCLES);

    hub_state_e       state;
    logic             sw_pend;
    logic [DR_W-1:0]  drain_cnt;
    logic [DW_W-1:0]  dwell_cnt;

    logic [N_CH-1:0][6:0] cap_int;
    logic [N_CH-1:0][6:0] q_int;

    // Mode sequencer: mode_o only moves in IDLE or on the DRAIN->START edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_o    <= 1'b0;
            start_o   <= 1'b0;
            stop_o    <= 1'b0;
            running   <= 1'b0;
            sw_pend   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            start_o <= 1'b0;
            stop_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    mode_o <= mode_req;
                    if (start_req) begin
                        state   <= S_START;
                        start_o <= 1'b1;
                    end
                end
                S_START: begin
                    state   <= S_RUN;
                    running <= 1'b1;
                end
                S_RUN: begin
                    if (stop_req || (mode_req != mode_o)) begin
                        state   <= S_STOP;
                        stop_o  <= 1'b1;
                        running <= 1'b0;
                        sw_pend <= !stop_req;
                    end
                end
                S_STOP: begin
                    state     <= S_DRAIN;
                    drain_cnt <= '0;
                end
                S_DRAIN: begin
                    if (!eng_busy || (drain_cnt == DR_W'(DRAIN_TO - 1))) begin
                        if (sw_pend && !stop_req) begin
                            mode_o  <= mode_req;
                            state   <= S_START;
                            start_o <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                        sw_pend <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + DR_W'(1);
                        if (stop_req)
                            sw_pend <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture path and per-channel alarms.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign cap_int[i] = soc_to_int(64'(ch_soc[i*DATA_W +: DATA_W]), DATA_W, FRAC_W);
        assign q_int[i]   = soc_to_int(64'(soc_q[i*DATA_W +: DATA_W]), DATA_W, FRAC_W);

        ekf_alarm_hyst #(
            .LOW_TH  (LOW_TH),
            .HIGH_TH (HIGH_TH),
            .HYST    (HYST)
        ) u_alarm (
            .clk        (clk),
            .rst        (rst),
            .cap        (ch_done[i]),
            .soc_int    (cap_int[i]),
            .low_alarm  (low_alarm[i]),
            .high_alarm (high_alarm[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            soc_q   <= '0;
            vrc_q   <= '0;
            valid_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_done[i]) begin
                    soc_q[i*DATA_W +: DATA_W] <= ch_soc[i*DATA_W +: DATA_W];
                    vrc_q[i*DATA_W +: DATA_W] <= ch_vrc[i*DATA_W +: DATA_W];
                    valid_q[i]                <= 1'b1;
                end
            end
        end
    end

    // Display scan: disp_soc trails disp_ch and captures by one register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            disp_ch   <= '0;
            disp_soc  <= BLANK;
        end else begin
            if (dwell_cnt == DW_W'(SCAN_CYCLES - 1)) begin
                dwell_cnt <= '0;
                disp_ch   <= (disp_ch == CH_W'(N_CH - 1)) ? '0 : disp_ch + CH_W'(1);
            end else begin
                dwell_cnt <= dwell_cnt + DW_W'(1);
            end
            disp_soc <= valid_q[disp_ch] ? q_int[disp_ch] : BLANK;
        end
    end

endmodule

// File: tb/tb_ekf_result_hub.sv
// Self-checking bench for ekf_result_hub: mode sequencing, drain timeout,
// capture/saturation/hysteresis vectors and the display scan.
module tb_ekf_result_hub;

    localparam int N_CH   = 4;
    localparam int DATA_W = 24;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   mode_req, start_req, stop_req, eng_busy;
    logic [N_CH-1:0]        ch_done;
    logic [N_CH*DATA_W-1:0] ch_soc, ch_vrc;
    logic                   mode_o, start_o, stop_o, running;
    logic [N_CH*DATA_W-1:0] soc_q, vrc_q;
    logic [N_CH-1:0]        valid_q, low_alarm, high_alarm;
    logic [1:0]             disp_ch;
    logic [6:0]             disp_soc;

    ekf_result_hub #(
        .N_CH(N_CH), .DATA_W(DATA_W), .FRAC_W(16), .LOW_TH(20), .HIGH_TH(95),
        .HYST(2), .DRAIN_TO(16), .SCAN_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .start_req(start_req),
        .stop_req(stop_req), .eng_busy(eng_busy), .ch_done(ch_done),
        .ch_soc(ch_soc), .ch_vrc(ch_vrc), .mode_o(mode_o), .start_o(start_o),
        .stop_o(stop_o), .running(running), .soc_q(soc_q), .vrc_q(vrc_q),
        .valid_q(valid_q), .low_alarm(low_alarm), .high_alarm(high_alarm),
        .disp_ch(disp_ch), .disp_soc(disp_soc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [23:0] soc;
        logic [23:0] vrc;
        logic [6:0]  disp;
        logic        lo;
        logic        hi;
    } vec_t;

    typedef struct {
        int          ch;
        logic [23:0] soc;
        logic [23:0] vrc;
        logic        lo;
        logic        hi;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 0;
    logic prev_mode = 1'b0;
    logic prev_act = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pct(input int p);
        return 24'(p) << 16;
    endfunction

    // mode_o must hold while the engines are being started or are running.
    always @(negedge clk) begin
        if (mon_en && prev_act && (start_o || running))
            chk("mode_stable", 64'(mode_o), 64'(prev_mode));
        prev_mode = mode_o;
        prev_act  = start_o || running;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic capture(input vec_t v);
        exp_t e;
        @(negedge clk);
        ch_done                 = '0;
        ch_done[v.ch]           = 1'b1;
        ch_soc[v.ch*24 +: 24]   = v.soc;
        ch_vrc[v.ch*24 +: 24]   = v.vrc;
        e = '{v.ch, v.soc, v.vrc, v.lo, v.hi};
        sb.push_back(e);
        @(negedge clk);
        ch_done = '0;
        e = sb.pop_front();
        chk("soc_q", 64'(soc_q[e.ch*24 +: 24]), 64'(e.soc));
        chk("vrc_q", 64'(vrc_q[e.ch*24 +: 24]), 64'(e.vrc));
        chk("valid_q", 64'(valid_q[e.ch]), 64'd1);
        chk("low_alarm", 64'(low_alarm[e.ch]), 64'(e.lo));
        chk("high_alarm", 64'(high_alarm[e.ch]), 64'(e.hi));
    endtask

    // Wait for the first cycle of a dwell on ch, then check disp_soc one cycle later.
    task automatic check_disp(input int ch, input logic [6:0] exp);
        logic [1:0] prev;
        bit         found;
        found = 0;
        prev  = disp_ch;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (disp_ch == 2'(ch) && prev != 2'(ch))
                found = 1;
            prev = disp_ch;
        end
        if (!found) begin
            chk("disp_wait", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
            chk("disp_soc", 64'(disp_soc), 64'(exp));
        end
    endtask

    vec_t vecs[11];

    initial begin
        int   cnt;
        bit   seen;
        logic [1:0] prev;
        bit   found;

        vecs[0]  = '{0, pct(19),     24'h000123, 7'd19,  1'b1, 1'b0};
        vecs[1]  = '{0, pct(21),     24'h000456, 7'd21,  1'b1, 1'b0};
        vecs[2]  = '{0, pct(22),     24'hFFF000, 7'd22,  1'b0, 1'b0};
        vecs[3]  = '{2, 24'h6E0000,  24'h012345, 7'd100, 1'b0, 1'b1};
        vecs[4]  = '{2, pct(94),     24'h000001, 7'd94,  1'b0, 1'b1};
        vecs[5]  = '{2, pct(93),     24'h000002, 7'd93,  1'b0, 1'b0};
        vecs[6]  = '{3, 24'hFF0000,  24'h800000, 7'd0,   1'b1, 1'b0};
        vecs[7]  = '{3, 24'h328000,  24'h000777, 7'd50,  1'b0, 1'b0};
        vecs[8]  = '{1, pct(96),     24'h0ABCDE, 7'd96,  1'b0, 1'b1};
        vecs[9]  = '{1, 24'h7F0000,  24'h000010, 7'd100, 1'b0, 1'b1};
        vecs[10] = '{1, pct(20),     24'h000020, 7'd20,  1'b0, 1'b0};

        rst = 1'b1; mode_req = 1'b0; start_req = 1'b0; stop_req = 1'b0;
        eng_busy = 1'b0; ch_done = '0; ch_soc = '0; ch_vrc = '0;
        do_reset();

        // Reset state
        chk("rst_mode_o", 64'(mode_o), 64'd0);
        chk("rst_pulses", 64'({start_o, stop_o, running}), 64'd0);
        chk("rst_valid", 64'(valid_q), 64'd0);
        chk("rst_alarms", 64'({low_alarm, high_alarm}), 64'd0);
        chk("rst_disp_ch", 64'(disp_ch), 64'd0);
        chk("rst_disp_soc", 64'(disp_soc), 64'd127);

        // Scan and blank: only ch1 valid at 55 %
        capture('{1, pct(55), 24'h000055, 7'd55, 1'b0, 1'b0});
        found = 0;
        prev  = disp_ch;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (disp_ch == 2'd0 && prev != 2'd0)
                found = 1;
            prev = disp_ch;
        end
        if (!found) chk("scan_wait", 64'd0, 64'd1);
        for (int k = 0; k < 5 && found; k++) begin
            chk("scan_ch", 64'(disp_ch), 64'(k % 4));
            @(negedge clk);
            chk("scan_soc", 64'(disp_soc), (k % 4 == 1) ? 64'd55 : 64'd127);
            repeat (2) @(negedge clk);
            chk("scan_dwell", 64'(disp_ch), 64'(k % 4));
            @(negedge clk);
        end

        // Start, then mode flip with engines idle
        do_reset();
        mon_en = 1;
        start_req = 1'b1;
        @(negedge clk);
        chk("start_o", 64'(start_o), 64'd1);
        chk("start_run", 64'(running), 64'd0);
        start_req = 1'b0;
        @(negedge clk);
        chk("running", 64'(running), 64'd1);
        chk("start_once", 64'(start_o), 64'd0);
        mode_req = 1'b1;
        @(negedge clk);
        chk("flip_stop_o", 64'(stop_o), 64'd1);
        chk("flip_mode_hold", 64'(mode_o), 64'd0);
        @(negedge clk);
        chk("drain_quiet", 64'({start_o, stop_o, running, mode_o}), 64'd0);
        @(negedge clk);
        chk("restart_o", 64'(start_o), 64'd1);
        chk("restart_mode", 64'(mode_o), 64'd1);
        @(negedge clk);
        chk("rerun", 64'(running), 64'd1);
        repeat (5) @(negedge clk);
        chk("run_mode", 64'(mode_o), 64'd1);

        // Drain timeout with engines stuck busy
        eng_busy = 1'b1;
        mode_req = 1'b0;
        @(negedge clk);
        chk("to_stop_o", 64'(stop_o), 64'd1);
        @(negedge clk);
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            cnt++;
            if (start_o) seen = 1;
        end
        chk("to_seen", 64'(seen), 64'd1);
        chk("to_cycles", 64'(cnt), 64'd16);
        chk("to_mode", 64'(mode_o), 64'd0);
        eng_busy = 1'b0;
        @(negedge clk);
        chk("to_run", 64'(running), 64'd1);

        // Stop and flip together: stop wins, no restart
        stop_req = 1'b1;
        mode_req = 1'b1;
        @(negedge clk);
        chk("sf_stop_o", 64'(stop_o), 64'd1);
        stop_req = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (start_o || running) seen = 1;
        end
        chk("sf_no_start", 64'(seen), 64'd0);
        chk("sf_idle_mode", 64'(mode_o), 64'd1);

        // Reset in the middle of a start
        start_req = 1'b1;
        @(negedge clk);
        chk("mr_start_o", 64'(start_o), 64'd1);
        start_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_clear", 64'({start_o, stop_o, running, mode_o}), 64'd0);
        @(negedge clk);
        chk("mr_idle", 64'({start_o, running}), 64'd0);
        mon_en = 0;

        // Capture / saturation / hysteresis vectors
        for (int i = 0; i < 11; i++) begin
            capture(vecs[i]);
            check_disp(vecs[i].ch, vecs[i].disp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
